fc_seq_ctrl: RTL and testbench
==============================

// Module: fc_seq_ctrl
// PURPOSE
//   Sequencer for the full_connected_16 FC datapath (VGG16 classifier tail).
//   On start, streams WIDTH*HEIGHT weights plus 1 bias from weight ROM/BRAM into the FC,
//   waits for load_weight_done, then forwards WIDTH*HEIGHT maxpool features into it.
//   Captures the single FC result and presents it on an output valid/ready port.
//   Weights persist across frames; reload happens only on request.
// PARAMETERS
//   WIDTH    4     feature-map width after maxpool
//   HEIGHT   4     feature-map height after maxpool
//   AW       8     weight-memory address width; must satisfy 2**AW >= NUM_W
//   TIMEOUT  1024  max cycles in a WAIT_* state before abort
//   derived: NUM_IN = WIDTH*HEIGHT, NUM_W = NUM_IN+1 (weights + bias)
// PORTS
//   clk                  in   1   clock, rising edge
//   reset                in   1   synchronous, active-high
//   start                in   1   begin one inference (IDLE only)
//   reload_w             in   1   sampled with start; 1 = force weight load
//   busy                 out  1   state != IDLE
//   done                 out  1   1-cycle pulse when result accepted downstream
//   err_timeout          out  1   sticky; cleared by reset or next accepted start
//   w_rd_en              out  1   weight-memory read strobe
//   w_rd_addr            out  AW  weight-memory address
//   w_rd_data            in   32  read data, valid 1 cycle after w_rd_en
//   s_valid              in   1   upstream feature valid
//   s_data               in   32  upstream feature word (fp32)
//   s_ready              out  1   high only in FEED with feed_cnt < NUM_IN
//   fc_load_weight       out  1   to FC load_weight
//   fc_weight            out  32  to FC weight
//   fc_load_weight_done  in   1   from FC
//   fc_valid_in          out  1   to FC valid_in
//   fc_data_in           out  32  to FC data_in
//   fc_feature           in   32  from FC feature
//   fc_valid_out         in   1   from FC valid_out
//   m_valid              out  1   result valid
//   m_data               out  32  result word
//   m_ready              in   1   downstream accept
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; w_loaded=0; counters 0. Reset wins over any event.
//   States: IDLE, LOAD_W, WAIT_WDONE, FEED, WAIT_OUT, RESULT.
//   IDLE:       on start: if (!w_loaded | reload_w) -> LOAD_W, else -> FEED; clear err_timeout.
//               start outside IDLE is ignored.
//   LOAD_W:     w_rd_en=1, w_rd_addr=0..NUM_W-1, one per cycle (NUM_W cycles).
//               fc_load_weight = w_rd_en delayed 1 cycle; fc_weight = w_rd_data, same cycle.
//               fc_load_weight is high for exactly NUM_W contiguous cycles, starting
//               1 cycle after LOAD_W entry. After the last address -> WAIT_WDONE.
//   WAIT_WDONE: on fc_load_weight_done=1: w_loaded<=1 -> FEED. A done already high during
//               the last fc_load_weight cycle is honoured on the next cycle.
//   FEED:       handshake = s_valid & s_ready. Registered: fc_valid_in<=handshake,
//               fc_data_in<=s_data (fc_data_in held when no handshake). Bubbles allowed;
//               fc_valid_in follows them. On the NUM_IN-th handshake -> WAIT_OUT;
//               s_ready drops the cycle after.
//   WAIT_OUT:   on fc_valid_out: m_data<=fc_feature, m_valid<=1 -> RESULT.
//               fc_valid_out in any other state is ignored.
//   RESULT:     m_valid, m_data held until m_ready. On m_valid&m_ready: m_valid<=0,
//               done pulse same edge -> IDLE.
//   Timeout:    wait counter counts cycles spent in WAIT_WDONE or WAIT_OUT; reset on entry.
//               Reaching TIMEOUT: err_timeout<=1 -> IDLE, outputs deasserted.
//               A timeout in WAIT_WDONE also clears w_loaded.
//   Width:      feed_cnt and wait counters are $clog2 sized; no wrap inside one frame.
// TESTING
//   T1 cold start (4x4): start -> w_rd_addr 0..16 over 17 cycles; fc_load_weight high for
//      17 cycles with fc_weight==mem[i]; pulse load_done; 16 words 0x3F800000+j with
//      s_valid=1 -> 16 contiguous fc_valid_in.
//   T2 result: fc_valid_out with fc_feature=0x40490FDB, m_ready=0 for 5 cycles -> m_valid
//      held, m_data stable; m_ready=1 -> done pulses 1 cycle, busy=0 next cycle.
//   T3 warm start: second start with reload_w=0 -> no w_rd_en, enters FEED directly;
//      reload_w=1 -> full 17-word load repeats.
//   T4 bubbles: s_valid toggled 1,0,0,1,... -> exactly 16 fc_valid_in pulses, data in order,
//      s_ready=0 after the 16th.
//   T5 timeout: TIMEOUT=32, never assert load_done -> err_timeout=1 after 32 WAIT cycles,
//      IDLE, w_loaded=0; next start clears err_timeout.
//   T6 reset mid-FEED (after 7 words) -> next cycle all outputs 0, IDLE; start -> reloads.

Source files
------------

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the full_connected_16 FC datapath: loads weights+bias from weight memory,
// streams maxpool features into the FC, then hands the single FC result downstream.
module fc_seq_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned HEIGHT  = 4,
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          reload_w,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          w_rd_en,
    output logic [AW-1:0] w_rd_addr,
    input  logic [31:0]   w_rd_data,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    output logic          fc_load_weight,
    output logic [31:0]   fc_weight,
    input  logic          fc_load_weight_done,
    output logic          fc_valid_in,
    output logic [31:0]   fc_data_in,
    input  logic [31:0]   fc_feature,
    input  logic          fc_valid_out,
    output logic          m_valid,
    output logic [31:0]   m_data,
    input  logic          m_ready
);

    localparam int unsigned NUM_IN = WIDTH * HEIGHT;
    localparam int unsigned NUM_W  = NUM_IN + 1;
    localparam int unsigned FW     = $clog2(NUM_IN + 1);
    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StWaitWdone,
        StFeed,
        StWaitOut,
        StResult
    } state_e;

    state_e        state_q, state_d;
    logic          w_loaded_q, w_loaded_d;
    logic          w_rd_en_q, w_rd_en_d;
    logic [AW-1:0] w_rd_addr_q, w_rd_addr_d;
    logic          fc_load_weight_q, fc_load_weight_d;
    logic          fc_valid_in_q, fc_valid_in_d;
    logic [31:0]   fc_data_in_q, fc_data_in_d;
    logic [FW-1:0] feed_cnt_q, feed_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          done_q, done_d;
    logic          err_timeout_q, err_timeout_d;
    logic          handshake;

    assign s_ready   = (state_q == StFeed) && (feed_cnt_q < FW'(NUM_IN));
    assign handshake = s_valid & s_ready;

    // Next-state and registered-output logic for the sequencer FSM.
    always_comb begin
        state_d          = state_q;
        w_loaded_d       = w_loaded_q;
        w_rd_en_d        = w_rd_en_q;
        w_rd_addr_d      = w_rd_addr_q;
        fc_load_weight_d = w_rd_en_q;  // memory read latency is one cycle
        fc_valid_in_d    = handshake;
        fc_data_in_d     = handshake ? s_data : fc_data_in_q;
        feed_cnt_d       = feed_cnt_q;
        wait_cnt_d       = wait_cnt_q;
        m_valid_d        = m_valid_q;
        m_data_d         = m_data_q;
        done_d           = 1'b0;
        err_timeout_d    = err_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_timeout_d = 1'b0;
                    if (!w_loaded_q || reload_w) begin
                        state_d     = StLoadW;
                        w_rd_en_d   = 1'b1;
                        w_rd_addr_d = '0;
                    end else begin
                        state_d    = StFeed;
                        feed_cnt_d = '0;
                    end
                end
            end
            StLoadW: begin
                if (w_rd_addr_q == AW'(NUM_W - 1)) begin
                    w_rd_en_d   = 1'b0;
                    w_rd_addr_d = '0;
                    wait_cnt_d  = '0;
                    state_d     = StWaitWdone;
                end else begin
                    w_rd_addr_d = w_rd_addr_q + AW'(1);
                end
            end
            StWaitWdone: begin
                // A done arriving on the timeout cycle still counts as success.
                if (fc_load_weight_done) begin
                    w_loaded_d = 1'b1;
                    feed_cnt_d = '0;
                    state_d    = StFeed;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    w_loaded_d    = 1'b0;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            StFeed: begin
                if (handshake) begin
                    feed_cnt_d = feed_cnt_q + FW'(1);
                    if (feed_cnt_q == FW'(NUM_IN - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = StWaitOut;
                    end
                end
            end
            StWaitOut: begin
                if (fc_valid_out) begin
                    m_data_d  = fc_feature;
                    m_valid_d = 1'b1;
                    state_d   = StResult;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            StResult: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            w_loaded_q       <= 1'b0;
            w_rd_en_q        <= 1'b0;
            w_rd_addr_q      <= '0;
            fc_load_weight_q <= 1'b0;
            fc_valid_in_q    <= 1'b0;
            fc_data_in_q     <= '0;
            feed_cnt_q       <= '0;
            wait_cnt_q       <= '0;
            m_valid_q        <= 1'b0;
            m_data_q         <= '0;
            done_q           <= 1'b0;
            err_timeout_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            w_loaded_q       <= w_loaded_d;
            w_rd_en_q        <= w_rd_en_d;
            w_rd_addr_q      <= w_rd_addr_d;
            fc_load_weight_q <= fc_load_weight_d;
            fc_valid_in_q    <= fc_valid_in_d;
            fc_data_in_q     <= fc_data_in_d;
            feed_cnt_q       <= feed_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            m_valid_q        <= m_valid_d;
            m_data_q         <= m_data_d;
            done_q           <= done_d;
            err_timeout_q    <= err_timeout_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign err_timeout    = err_timeout_q;
    assign w_rd_en        = w_rd_en_q;
    assign w_rd_addr      = w_rd_addr_q;
    assign fc_load_weight = fc_load_weight_q;
    // Gated so the FC weight bus reads zero whenever no weight is being delivered.
    assign fc_weight      = fc_load_weight_q ? w_rd_data : 32'h0;
    assign fc_valid_in    = fc_valid_in_q;
    assign fc_data_in     = fc_data_in_q;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Scoreboard bench for fc_seq_ctrl: stimulus pushes expected reads, weights, features and
// results into queues; negedge monitors pop and compare whenever the DUT presents them.
module tb_fc_seq_ctrl;

    localparam int NUM_W = 17;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        reload_w = 1'b0;
    logic        busy, done, err_timeout, w_rd_en, s_ready;
    logic [7:0]  w_rd_addr;
    logic [31:0] w_rd_data = 32'h0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        fc_load_weight;
    logic [31:0] fc_weight;
    logic        fc_load_weight_done = 1'b0;
    logic        fc_valid_in;
    logic [31:0] fc_data_in;
    logic [31:0] fc_feature = 32'h0;
    logic        fc_valid_out = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    int          exp_addr[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_feat[$];
    logic [31:0] exp_res[$];
    int          vin_hi = 0;
    int          vin_rises = 0;
    int          done_cnt = 0;
    logic        vin_prev = 1'b0;

    fc_seq_ctrl #(
        .WIDTH  (4),
        .HEIGHT (4),
        .AW     (8),
        .TIMEOUT(32)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .reload_w           (reload_w),
        .busy               (busy),
        .done               (done),
        .err_timeout        (err_timeout),
        .w_rd_en            (w_rd_en),
        .w_rd_addr          (w_rd_addr),
        .w_rd_data          (w_rd_data),
        .s_valid            (s_valid),
        .s_data             (s_data),
        .s_ready            (s_ready),
        .fc_load_weight     (fc_load_weight),
        .fc_weight          (fc_weight),
        .fc_load_weight_done(fc_load_weight_done),
        .fc_valid_in        (fc_valid_in),
        .fc_data_in         (fc_data_in),
        .fc_feature         (fc_feature),
        .fc_valid_out       (fc_valid_out),
        .m_valid            (m_valid),
        .m_data             (m_data),
        .m_ready            (m_ready)
    );

    always #5 clk = ~clk;

    // Weight memory model: registered read, one cycle of latency.
    always @(posedge clk) begin
        if (w_rd_en === 1'b1) w_rd_data <= mem[w_rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
    endtask

    // Monitors: compare every presented output against the scoreboard queues.
    always @(negedge clk) begin
        if (w_rd_en === 1'b1) begin
            if (exp_addr.size() == 0) fail_now("rd_unexpected", 64'(w_rd_addr));
            else chk("rd_addr", 64'(w_rd_addr), 64'(exp_addr.pop_front()));
        end
        if (fc_load_weight === 1'b1) begin
            if (exp_w.size() == 0) fail_now("weight_unexpected", 64'(fc_weight));
            else chk("fc_weight", 64'(fc_weight), 64'(exp_w.pop_front()));
        end
        if (fc_valid_in === 1'b1) begin
            vin_hi++;
            if (!vin_prev) vin_rises++;
            if (exp_feat.size() == 0) fail_now("feat_unexpected", 64'(fc_data_in));
            else chk("fc_data_in", 64'(fc_data_in), 64'(exp_feat.pop_front()));
        end
        vin_prev = (fc_valid_in === 1'b1);
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_res.size() == 0) fail_now("res_unexpected", 64'(m_data));
            else chk("m_data", 64'(m_data), 64'(exp_res.pop_front()));
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit rl, input bit exp_load);
        if (exp_load) begin
            for (int i = 0; i < NUM_W; i++) begin
                exp_addr.push_back(i);
                exp_w.push_back(mem[i]);
            end
        end
        start = 1'b1;
        reload_w = rl;
        tick();
        start = 1'b0;
        reload_w = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_rd_en", 64'(w_rd_en), 64'(exp_load));
        chk("start_s_ready", 64'(s_ready), 64'(!exp_load));
    endtask

    // mode 0: pulse load_done after the load, 1: done was held high already, 2: never.
    task automatic load_phase(input int mode);
        int  hi = 0;
        int  rises = 0;
        bit  prev = 1'b0;
        bit  ended = 1'b0;
        for (int n = 0; n < 40 && !ended; n++) begin
            tick();
            if (fc_load_weight) begin
                hi++;
                if (!prev) rises++;
            end else if (hi > 0) begin
                ended = 1'b1;
            end
            prev = fc_load_weight;
        end
        chk("load_cycles", 64'(hi), 64'(NUM_W));
        chk("load_contig", 64'(rises), 64'(1));
        chk("load_ended", 64'(ended), 64'(1));
        if (mode == 1) begin
            fc_load_weight_done = 1'b0;
        end else if (mode == 0) begin
            fc_load_weight_done = 1'b1;
            tick();
            fc_load_weight_done = 1'b0;
        end
    endtask

    // mode 0: s_valid always high, mode 1: s_valid pattern 1,0,0 repeating.
    task automatic feed(input int n, input logic [31:0] base, input int mode);
        int j = 0;
        bit hs;
        for (int i = 0; i < n; i++) exp_feat.push_back(base + 32'(i));
        for (int k = 0; k < 200 && j < n; k++) begin
            s_valid = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            s_data = s_valid ? base + 32'(j) : 32'hDEAD_BEEF;
            hs = s_valid && s_ready;
            tick();
            if (hs) j++;
        end
        s_valid = 1'b0;
        chk("feed_words", 64'(j), 64'(n));
    endtask

    task automatic result(input logic [31:0] feat, input int stall);
        exp_res.push_back(feat);
        chk("wait_out_busy", 64'(busy), 64'(1));
        fc_valid_out = 1'b1;
        fc_feature = feat;
        tick();
        fc_valid_out = 1'b0;
        fc_feature = ~feat;
        chk("m_valid_set", 64'(m_valid), 64'(1));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("m_hold", {31'h0, m_valid, m_data}, {31'h0, 1'b1, feat});
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_after", 64'(busy), 64'(0));
        chk("m_valid_clr", 64'(m_valid), 64'(0));
        tick();
        chk("done_once", 64'(done), 64'(0));
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, err_timeout, w_rd_en, w_rd_addr, s_ready, fc_load_weight,
                   fc_valid_in, m_valid}, 64'h0);
        chk({name, "_data"}, {fc_weight, fc_data_in}, 64'h0);
        chk({name, "_m_data"}, 64'(m_data), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r0, p0, n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h4100_0000 + 32'(i) * 32'h0000_0111;
        tick();
        tick();
        reset = 1'b0;
        chk_all_zero("reset_state");

        // T1 cold start with reload_w=0 must still load; contiguous features.
        do_start(1'b0, 1'b1);
        load_phase(0);
        r0 = vin_rises;
        p0 = vin_hi;
        feed(16, 32'h3F80_0000, 0);
        chk("t1_s_ready_low", 64'(s_ready), 64'(0));
        // T2 result held under backpressure.
        result(32'h4049_0FDB, 5);
        chk("t1_vin_pulses", 64'(vin_hi - p0), 64'(16));
        chk("t1_vin_contig", 64'(vin_rises - r0), 64'(1));

        // fc_valid_out in IDLE is ignored.
        fc_valid_out = 1'b1;
        fc_feature = 32'hBAD0_0001;
        tick();
        fc_valid_out = 1'b0;
        chk("idle_valid_out", 64'({busy, m_valid}), 64'(0));

        // T3 warm start skips the load; then forced reload with done held early.
        do_start(1'b0, 1'b0);
        feed(16, 32'h3F00_0000, 0);
        result(32'h1234_5678, 0);
        fc_load_weight_done = 1'b1;
        do_start(1'b1, 1'b1);
        load_phase(1);
        feed(16, 32'h3E00_0000, 0);
        result(32'h0BAD_CAFE, 1);

        // T4 bubbles, with a start held during FEED that must be ignored.
        do_start(1'b0, 1'b0);
        start = 1'b1;
        reload_w = 1'b1;
        r0 = vin_rises;
        p0 = vin_hi;
        feed(16, 32'h4000_0000, 1);
        start = 1'b0;
        reload_w = 1'b0;
        chk("t4_s_ready_low", 64'(s_ready), 64'(0));
        result(32'h5555_AAAA, 0);
        chk("t4_vin_pulses", 64'(vin_hi - p0), 64'(16));
        chk("t4_vin_bubbles", 64'(vin_rises - r0), 64'(16));

        // T5 timeout in WAIT_WDONE: 32 wait cycles, one already spent in load_phase.
        do_start(1'b1, 1'b1);
        load_phase(2);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("t5_timeout_cycles", 64'(n), 64'(31));
        chk("t5_err_timeout", 64'(err_timeout), 64'(1));
        chk("t5_outputs_idle", 64'({w_rd_en, s_ready, fc_load_weight, m_valid}), 64'(0));
        do_start(1'b0, 1'b1);
        chk("t5_err_cleared", 64'(err_timeout), 64'(0));
        load_phase(0);
        feed(16, 32'h3F80_0100, 0);
        result(32'h0000_0042, 0);

        // T6 reset mid-FEED after 7 words, then a start must reload.
        do_start(1'b0, 1'b0);
        feed(7, 32'h3C00_0000, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("t6_reset");
        do_start(1'b0, 1'b1);
        load_phase(0);
        feed(16, 32'h3D00_0000, 0);
        result(32'h7F7F_0001, 2);

        tick();
        chk("q_addr_empty", 64'(exp_addr.size()), 64'(0));
        chk("q_w_empty", 64'(exp_w.size()), 64'(0));
        chk("q_feat_empty", 64'(exp_feat.size()), 64'(0));
        chk("q_res_empty", 64'(exp_res.size()), 64'(0));
        chk("done_count", 64'(done_cnt), 64'(6));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
